// File: rtl/mem_bus_responder_pkg.sv
// Shared encodings for the CPU data bus target: access/length codes, FSM states,
// byte-lane constants and lane helpers used by mem_bus_responder.
package mem_bus_responder_pkg;

    typedef enum logic [1:0] {
        MEM_ACCESS_NONE = 2'd0,
        MEM_ACCESS_R    = 2'd1,
        MEM_ACCESS_W    = 2'd2,
        MEM_ACCESS_X    = 2'd3
    } MEM_ACCESS_T;

    typedef enum logic [1:0] {
        MEM_LEN_BYTE = 2'd0,
        MEM_LEN_HALF = 2'd1,
        MEM_LEN_WORD = 2'd2
    } MEM_LEN;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_ALL     = 4'b1111;

    function automatic logic [3:0] byte_en(input MEM_LEN len, input logic [1:0] lane);
        logic [3:0] be;
        be = BE_NONE;
        case (len)
            MEM_LEN_BYTE: be = BE_BYTE0 << lane;
            MEM_LEN_HALF: be = lane[1] ? BE_HALF_HI : BE_HALF_LO;
            default:      be = BE_ALL;
        endcase
        return be;
    endfunction

    // Right-justified write data copied to every lane; byte enables pick the live bytes.
    function automatic logic [31:0] wr_replicate(input MEM_LEN len, input logic [31:0] d);
        logic [31:0] w;
        w = d;
        case (len)
            MEM_LEN_BYTE: w = {4{d[7:0]}};
            MEM_LEN_HALF: w = {2{d[15:0]}};
            default:      w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] rd_extract(input MEM_LEN len, input logic [1:0] lane,
                                               input logic sgn, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        r = word;
        case (len)
            MEM_LEN_BYTE: r = {{24{sgn & b[7]}}, b};
            MEM_LEN_HALF: r = {{16{sgn & h[15]}}, h};
            default:      r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_responder_ram.sv
// Single-port word RAM, synchronous registered read and per-byte write enables.
module mem_word_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  re,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Read data register only updates on re, so it holds across wait states.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Data bus target serving a local word RAM: lane select, extension, wait states,
// alignment/range errors and a HOLD state that prevents double service of a held request.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        res,
    input  MEM_ACCESS_T db_accessType,
    input  logic [31:0] db_addr,
    input  MEM_LEN      db_memLen,
    input  logic        db_signed,
    input  logic [31:0] db_dataIn,
    output logic [31:0] db_dataOut,
    output logic        db_ready,
    output logic        db_err
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef struct packed {
        MEM_ACCESS_T           kind;
        logic [ADDR_WIDTH-1:0] idx;
        logic [1:0]            lane;
        MEM_LEN                len;
        logic                  sgn;
        logic [31:0]           data;
        logic                  err;
    } lat_t;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    lat_t             lat;

    logic [31:0]           off_in;
    logic                  mis_in;
    logic                  err_in;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_re;
    logic                  ram_we;
    logic [31:0]           ram_rdata;

    assign off_in = db_addr - BASE_ADDR;

    always_comb begin
        mis_in = 1'b0;
        case (db_memLen)
            MEM_LEN_BYTE: mis_in = 1'b0;
            MEM_LEN_HALF: mis_in = db_addr[0];
            default:      mis_in = |db_addr[1:0];
        endcase
    end

    assign err_in = mis_in | (db_addr < BASE_ADDR) | ((off_in >> (ADDR_WIDTH + 2)) != 32'd0);
    assign accept = (state == ST_IDLE) && (db_accessType != MEM_ACCESS_NONE) && !res;

    always_ff @(posedge clk) begin
        if (res) begin
            state <= ST_IDLE;
            cnt   <= '0;
            lat   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (db_accessType != MEM_ACCESS_NONE) begin
                        lat.kind <= db_accessType;
                        lat.idx  <= off_in[ADDR_WIDTH+1:2];
                        lat.lane <= off_in[1:0];
                        lat.len  <= db_memLen;
                        lat.sgn  <= db_signed;
                        lat.data <= db_dataIn;
                        lat.err  <= err_in;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                        state    <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) state <= ST_RESP;
                end
                ST_RESP: state <= ST_HOLD;
                default: begin
                    if (db_accessType == MEM_ACCESS_NONE) state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read is issued at accept from the live address; the write uses the latched index.
    assign ram_addr = (state == ST_IDLE) ? off_in[ADDR_WIDTH+1:2] : lat.idx;
    assign ram_re   = accept;
    assign ram_we   = (state == ST_RESP) && (lat.kind == MEM_ACCESS_W) && !lat.err && !res;

    mem_word_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .re   (ram_re),
        .we   (ram_we),
        .be   (byte_en(lat.len, lat.lane)),
        .wdata(wr_replicate(lat.len, lat.data)),
        .rdata(ram_rdata)
    );

    assign db_ready   = (state == ST_RESP);
    assign db_err     = (state == ST_RESP) && lat.err;
    assign db_dataOut = ((state == ST_RESP) && !lat.err && (lat.kind != MEM_ACCESS_W))
                        ? rd_extract(lat.len, lat.lane, lat.sgn, ram_rdata) : 32'd0;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed and randomized checks of mem_bus_responder against a byte-array model.
module tb_mem_bus_responder;
    import mem_bus_responder_pkg::*;

    localparam logic [31:0] BASE1  = 32'h0000_1000;
    localparam int          BYTES1 = 4 * 64;

    logic        clk = 1'b0;
    logic        res    [2];
    MEM_ACCESS_T at     [2];
    logic [31:0] addr   [2];
    MEM_LEN      len    [2];
    logic        sgn    [2];
    logic [31:0] din    [2];
    logic [31:0] dout   [2];
    logic        rdy    [2];
    logic        er     [2];

    int checks = 0;
    int errors = 0;
    logic [7:0] m1 [BYTES1];

    always #5 clk = ~clk;

    mem_bus_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u0 (
        .clk(clk), .res(res[0]), .db_accessType(at[0]), .db_addr(addr[0]),
        .db_memLen(len[0]), .db_signed(sgn[0]), .db_dataIn(din[0]),
        .db_dataOut(dout[0]), .db_ready(rdy[0]), .db_err(er[0]));

    mem_bus_responder #(.ADDR_WIDTH(6), .BASE_ADDR(BASE1), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .res(res[1]), .db_accessType(at[1]), .db_addr(addr[1]),
        .db_memLen(len[1]), .db_signed(sgn[1]), .db_dataIn(din[1]),
        .db_dataOut(dout[1]), .db_ready(rdy[1]), .db_err(er[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_acc(input int i, input MEM_ACCESS_T t, input logic [31:0] a,
                          input MEM_LEN l, input logic s, input logic [31:0] d,
                          output logic [31:0] q, output logic e, output int cyc);
        logic seen;
        seen = 1'b0; cyc = 0; q = '0; e = 1'b0;
        @(negedge clk);
        at[i] = t; addr[i] = a; len[i] = l; sgn[i] = s; din[i] = d;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            // address/data wander after accept; only latched values may matter
            addr[i] = $urandom; din[i] = $urandom;
            if (rdy[i]) begin
                seen = 1'b1; q = dout[i]; e = er[i];
            end
        end
        at[i] = MEM_ACCESS_NONE;
        chk("ready_seen", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    function automatic logic model_err(input logic [31:0] a, input MEM_LEN l);
        if (a < BASE1 || (a - BASE1) >= BYTES1) return 1'b1;
        if (l == MEM_LEN_HALF && a % 2 != 0) return 1'b1;
        if (l == MEM_LEN_WORD && a % 4 != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int nbytes(input MEM_LEN l);
        return (l == MEM_LEN_BYTE) ? 1 : (l == MEM_LEN_HALF) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input MEM_LEN l, input logic s);
        int off, n;
        longint v;
        off = int'(a - BASE1);
        n = nbytes(l);
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(m1[off + k]) << (8 * k);
        if (s && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    task automatic model_write(input logic [31:0] a, input MEM_LEN l, input logic [31:0] d);
        int off;
        off = int'(a - BASE1);
        for (int k = 0; k < nbytes(l); k++) m1[off + k] = 8'(d >> (8 * k));
    endtask

    initial begin
        logic [31:0] q, a, d, exp;
        logic        e, s, me;
        int          cyc, pulses;
        MEM_ACCESS_T t;
        MEM_LEN      l;

        for (int i = 0; i < 2; i++) begin
            res[i] = 1'b1; at[i] = MEM_ACCESS_NONE; addr[i] = '0;
            len[i] = MEM_LEN_WORD; sgn[i] = 1'b0; din[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(rdy[i]), 32'd0);
            chk("rst_err", 32'(er[i]), 32'd0);
            chk("rst_data", dout[i], 32'd0);
        end
        res[0] = 1'b0; res[1] = 1'b0;

        // aligned word, one wait state
        do_acc(0, MEM_ACCESS_W, 32'h10, MEM_LEN_WORD, 1'b0, 32'hDEADBEEF, q, e, cyc);
        chk("w10_err", 32'(e), 32'd0);
        chk("w10_lat", 32'(cyc), 32'd2);
        do_acc(0, MEM_ACCESS_R, 32'h10, MEM_LEN_WORD, 1'b1, 32'h0, q, e, cyc);
        chk("r10_data", q, 32'hDEADBEEF);
        chk("r10_err", 32'(e), 32'd0);
        chk("r10_lat", 32'(cyc), 32'd2);

        do_acc(0, MEM_ACCESS_R, 32'h13, MEM_LEN_BYTE, 1'b1, 32'h0, q, e, cyc);
        chk("rb13_s", q, 32'hFFFFFFDE);
        do_acc(0, MEM_ACCESS_X, 32'h13, MEM_LEN_BYTE, 1'b0, 32'h0, q, e, cyc);
        chk("rb13_u", q, 32'h000000DE);
        do_acc(0, MEM_ACCESS_R, 32'h10, MEM_LEN_HALF, 1'b1, 32'h0, q, e, cyc);
        chk("rh10_s", q, 32'hFFFFBEEF);
        do_acc(0, MEM_ACCESS_R, 32'h12, MEM_LEN_HALF, 1'b0, 32'h0, q, e, cyc);
        chk("rh12_u", q, 32'h0000DEAD);

        do_acc(0, MEM_ACCESS_W, 32'h11, MEM_LEN_BYTE, 1'b0, 32'h000000A5, q, e, cyc);
        do_acc(0, MEM_ACCESS_R, 32'h10, MEM_LEN_WORD, 1'b0, 32'h0, q, e, cyc);
        chk("partial_w", q, 32'hDEADA5EF);

        do_acc(0, MEM_ACCESS_R, 32'h11, MEM_LEN_HALF, 1'b0, 32'h0, q, e, cyc);
        chk("mis_err", 32'(e), 32'd1);
        chk("mis_data", q, 32'd0);

        do_acc(0, MEM_ACCESS_W, 32'h0, MEM_LEN_WORD, 1'b0, 32'h01234567, q, e, cyc);
        do_acc(0, MEM_ACCESS_W, 32'h4000, MEM_LEN_WORD, 1'b0, 32'hFFFFFFFF, q, e, cyc);
        chk("oor_err", 32'(e), 32'd1);
        do_acc(0, MEM_ACCESS_R, 32'h0, MEM_LEN_WORD, 1'b0, 32'h0, q, e, cyc);
        chk("oor_noch", q, 32'h01234567);

        // reset during the wait state of a write
        do_acc(0, MEM_ACCESS_W, 32'h20, MEM_LEN_WORD, 1'b0, 32'hCAFEF00D, q, e, cyc);
        @(negedge clk);
        at[0] = MEM_ACCESS_W; addr[0] = 32'h20; len[0] = MEM_LEN_WORD; din[0] = 32'h12345678;
        @(negedge clk);
        chk("rw_wait_rdy", 32'(rdy[0]), 32'd0);
        res[0] = 1'b1; at[0] = MEM_ACCESS_NONE;
        @(negedge clk);
        chk("rw_rst_rdy", 32'(rdy[0]), 32'd0);
        res[0] = 1'b0;
        @(negedge clk);
        chk("rw_rst_rdy2", 32'(rdy[0]), 32'd0);
        do_acc(0, MEM_ACCESS_R, 32'h20, MEM_LEN_WORD, 1'b0, 32'h0, q, e, cyc);
        chk("rw_keep", q, 32'hCAFEF00D);
        chk("rw_after_lat", 32'(cyc), 32'd2);

        // zero-wait instance: fill RAM so every model byte is defined
        for (int w = 0; w < 64; w++) begin
            d = $urandom;
            a = BASE1 + 32'(4 * w);
            do_acc(1, MEM_ACCESS_W, a, MEM_LEN_WORD, 1'b0, d, q, e, cyc);
            model_write(a, MEM_LEN_WORD, d);
        end

        // request held for several cycles after ready gives a single pulse
        @(negedge clk);
        at[1] = MEM_ACCESS_R; addr[1] = BASE1 + 32'h8; len[1] = MEM_LEN_WORD; sgn[1] = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rdy[1]) begin
                pulses++;
                chk("hold_data", dout[1], model_read(BASE1 + 32'h8, MEM_LEN_WORD, 1'b0));
            end
        end
        chk("hold_pulses", 32'(pulses), 32'd1);
        at[1] = MEM_ACCESS_NONE;
        @(negedge clk);
        do_acc(1, MEM_ACCESS_R, BASE1 + 32'hC, MEM_LEN_WORD, 1'b0, 32'h0, q, e, cyc);
        chk("hold_next_lat", 32'(cyc), 32'd1);
        chk("hold_next_data", q, model_read(BASE1 + 32'hC, MEM_LEN_WORD, 1'b0));

        // reset wins over a simultaneous request
        @(negedge clk);
        res[1] = 1'b1; at[1] = MEM_ACCESS_R; addr[1] = BASE1;
        @(negedge clk);
        res[1] = 1'b0; at[1] = MEM_ACCESS_NONE;
        chk("rst_req_rdy", 32'(rdy[1]), 32'd0);
        @(negedge clk);
        chk("rst_req_rdy2", 32'(rdy[1]), 32'd0);

        do_acc(1, MEM_ACCESS_R, BASE1 - 32'h4, MEM_LEN_WORD, 1'b0, 32'h0, q, e, cyc);
        chk("below_base", 32'(e), 32'd1);

        // random traffic against the byte-array model
        for (int n = 0; n < 200; n++) begin
            t = MEM_ACCESS_T'($urandom_range(1, 3));
            l = MEM_LEN'($urandom_range(0, 2));
            s = 1'($urandom);
            d = $urandom;
            a = BASE1 - 32'd16 + 32'($urandom_range(0, BYTES1 + 31));
            me = model_err(a, l);
            exp = (me || t == MEM_ACCESS_W) ? 32'd0 : model_read(a, l, s);
            do_acc(1, t, a, l, s, d, q, e, cyc);
            if (t == MEM_ACCESS_W && !me) model_write(a, l, d);
            chk("rnd_err", 32'(e), 32'(me));
            chk("rnd_lat", 32'(cyc), 32'd1);
            if (t != MEM_ACCESS_W) chk("rnd_data", q, exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Bus target for the CPU data bus: accepts read, write and instruction-fetch requests (`db_accessType`, `db_addr`, `db_memLen`, `db_signed`, write data) and completes each with a one-cycle `db_ready` pulse. It sits on the physical side of the MMU and serves a local word-organised RAM.
- Handles byte/half/word lanes, sign or zero extension, and a configurable number of wait states.
- Flags misaligned and out-of-range accesses with `db_err`.

## Interface
- `ADDR_WIDTH`, 12, log2 of RAM depth in 32-bit words (default 16 KiB).
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- `WAIT_CYCLES`, 1, extra cycles between accept and `db_ready`; 0 is legal.
- `clk` in 1: the single clock; all state updates on posedge.
- `res` in 1: reset, synchronous, active-high.
- `db_accessType` in `MEM_ACCESS_T`: NONE / R / W / X; the initiator holds it stable until `db_ready`.
- `db_addr` in 32: physical byte address.
- `db_memLen` in `MEM_LEN`: byte / half / word.
- `db_signed` in 1: sign-extend read data when 1, zero-extend when 0.
- `db_dataIn` in 32: write data, right-justified.
- `db_dataOut` out 32: read data, valid only while `db_ready`=1.
- `db_ready` out 1: one-cycle completion pulse.
- `db_err` out 1: qualifies `db_ready`; 1 means the access was rejected.

## Operation
- Byte order is little-endian. Lane = `db_addr[1:0]`. Word index = `(db_addr - BASE_ADDR) >> 2`.
- Misaligned access is an error:
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
- Out-of-range access is an error: word index ≥ 2^ADDR_WIDTH, or `addr` < `BASE_ADDR`.
- Error handling: writes are suppressed, `db_dataOut`=0, `db_err`=1 with `db_ready`.
- R and X are identical.
- Read data: select the lane (byte: 8 bits at `lane*8`; half: 16 bits at `lane[1]*16`), then extend to 32 bits per the latched `signed` flag. Word reads ignore `signed`.
- Write: generate byte enables (byte: 1 bit, half: 2 bits, word: all 4). Replicate the low bits of the write data across lanes. Bytes not enabled are unchanged.
- FSM states:
  - **IDLE**: if `db_accessType`≠NONE, latch addr/len/signed/data/type, compute the error flag, issue the RAM read, and load the wait counter with `WAIT_CYCLES`. Go to WAIT, or to RESP if `WAIT_CYCLES`=0.
  - **WAIT**: decrement the counter; on reaching 0 go to RESP.
  - **RESP**: `db_ready`=1, drive `db_dataOut`/`db_err`. A non-error write commits to RAM on this clock edge. Go to HOLD.
  - **HOLD**: wait until `db_accessType`=NONE, then go to IDLE. This ensures a request still held after `db_ready` is not served twice.
- All address/len/data decisions use latched values only; input changes after accept are ignored.

## Timing
- Reset values: state IDLE, `db_ready`=0, `db_err`=0, `db_dataOut`=0, counter 0. RAM contents are not cleared.
- Latency: request first sampled in IDLE at edge 0 → `db_ready` high during cycle `1+WAIT_CYCLES` for exactly one cycle.
- Minimum spacing: 1 cycle of NONE is required between requests. A new request is accepted at the earliest on the edge after HOLD observes NONE.
- Read-after-write to the same address returns the new data; the write commits before any later accept.
- `res` asserted in WAIT or RESP: the pending write is dropped if its commit edge has not occurred, `db_ready` is 0 on the next cycle, and the FSM is in IDLE.
- `res` and a request together: reset wins; the request is not accepted that cycle.

## Structure
- `DataBus.vh` stays the source of the `MEM_ACCESS_*` and `MEM_LEN` encodings.
- New `mem_bus.vh` holds:
  - FSM state localparams;
  - lane/byte-enable helper constants.
- Sub-module `mem_word_ram`:
  - 2^ADDR_WIDTH × 32 array;
  - synchronous read;
  - 4-bit byte-enable write;
  - one port.
- Alignment/range checking, lane selection and extension stay in `mem_bus_responder`.

## Test plan
- **Aligned word, `WAIT_CYCLES`=1**: write 0xDEADBEEF to 0x10, then read word 0x10 → `db_ready` in cycle 2 after accept for both accesses, read returns 0xDEADBEEF, `db_err`=0.
- **Byte reads with extension**: after the above, read byte 0x13 with signed=1 → 0xFFFFFFDE; with signed=0 → 0x000000DE. Read half 0x10 with signed=1 → 0xFFFFBEEF.
- **Partial write**: write byte 0xA5 to 0x11 → subsequent word read 0x10 returns 0xDEADA5EF.
- **Errors**:
  - half read at 0x11 → `db_ready`+`db_err`, data 0;
  - word write to `BASE_ADDR`+4·2^ADDR_WIDTH → `db_err`=1, no RAM change (verify by reading word 0).
- **Handshake and zero wait**: with `WAIT_CYCLES`=0, hold the request 3 cycles after `db_ready` → exactly one `db_ready` pulse. Drop to NONE for one cycle, then issue a new read → accepted and served.
- **Reset mid-write**: assert `res` in WAIT of a word write 0x12345678 to 0x20 → no `db_ready`, word 0x20 keeps its prior value, next access completes normally.
